regfile_write_buffer: RTL and testbench

Write-side companion to the 32x32 register file. Collects result writes from two producers, the single-cycle ALU and the multi-cycle multiply/divide unit, in a small in-order FIFO. It drains exactly one entry per cycle onto the register file write port (WE3/A3/WD3). It also answers two decode-stage lookups, so that operands still sitting in the buffer can be forwarded or stalled on.

---
 rtl/regfile_write_buffer.sv | 107 ++++++++++
 tb/tb_regfile_write_buffer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/regfile_write_buffer.sv
// Small in-order write buffer in front of the register file write port.
// It merges ALU and mul/div results and forwards pending values to decode.
module regfile_write_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [AW-1:0]              alu_addr,
  input  logic [DW-1:0]              alu_data,
  output logic                       alu_ready,
  input  logic                       md_valid,
  input  logic [AW-1:0]              md_addr,
  input  logic [DW-1:0]              md_data,
  output logic                       md_ready,
  output logic                       we3,
  output logic [AW-1:0]              a3,
  output logic [DW-1:0]              wd3,
  input  logic [AW-1:0]              q_a1,
  input  logic [AW-1:0]              q_a2,
  output logic                       hit1,
  output logic                       hit2,
  output logic [DW-1:0]              fwd1,
  output logic [DW-1:0]              fwd2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, md_ptr;
  logic [CW-1:0] free;
  logic          pop, alu_take, md_take;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = !empty;

  // The head leaves at this edge, so its slot is reusable in the same cycle.
  assign free = CW'(DEPTH) - count + CW'(pop);

  // Handshake: a request transfers on an edge where valid && ready. Ready may
  // depend on valid of the other producer (md_ready on alu_valid), never on
  // its own valid; producers must not wait for ready before raising valid.
  // Writes to r0 handshake normally but never allocate a slot.
  assign alu_ready = (free >= CW'(1));
  assign alu_take  = alu_valid && alu_ready && (alu_addr != '0);
  assign md_ready  = (free >= CW'(2)) || ((free >= CW'(1)) && !alu_take);
  assign md_take   = md_valid && md_ready && (md_addr != '0);
  assign md_ptr    = wr_ptr + PW'(alu_take);

  assign we3 = pop;
  assign a3  = pop ? addr_mem[rd_ptr] : '0;
  assign wd3 = pop ? data_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(alu_take) + PW'(md_take);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(alu_take) + CW'(md_take) - CW'(pop);
    end
  end

  // Storage is not reset; entries beyond count are simply ignored.
  always_ff @(posedge clk) begin
    if (alu_take) begin
      addr_mem[wr_ptr] <= alu_addr;
      data_mem[wr_ptr] <= alu_data;
    end
    if (md_take) begin
      addr_mem[md_ptr] <= md_addr;
      data_mem[md_ptr] <= md_data;
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx  = '0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    fwd1 = '0;
    fwd2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if ((q_a1 != '0) && (addr_mem[idx] == q_a1)) begin
          hit1 = 1'b1;
          fwd1 = data_mem[idx];
        end
        if ((q_a2 != '0) && (addr_mem[idx] == q_a2)) begin
          hit2 = 1'b1;
          fwd2 = data_mem[idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_buffer.sv
// Self-checking bench for regfile_write_buffer: reference queue of pending
// writes, scenario tasks, and a random mixed-traffic run.
module tb_regfile_write_buffer;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, md_valid;
  logic [AW-1:0] alu_addr, md_addr;
  logic [DW-1:0] alu_data, md_data;
  logic          alu_ready, md_ready;
  logic          we3;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] q_a1, q_a2;
  logic          hit1, hit2;
  logic [DW-1:0] fwd1, fwd2;
  logic [CW-1:0] count;
  logic          full, empty;

  logic [AW+DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  regfile_write_buffer #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
    .we3(we3), .a3(a3), .wd3(wd3),
    .q_a1(q_a1), .q_a2(q_a2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive at negedge, check against the reference queue,
  // then record what the upcoming posedge should accept.
  task automatic cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    int sz, fr;
    logic er_a, er_m, a_take, h1, h2;
    logic [DW-1:0] f1, f2;
    @(negedge clk);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    md_valid  = mv; md_addr  = ma; md_data  = md;
    #1;
    sz = exp_q.size();
    fr = DEPTH - sz + ((sz > 0) ? 1 : 0);
    er_a = (fr >= 1);
    a_take = av && er_a && (aa != '0);
    er_m = (fr >= 2) || ((fr >= 1) && !a_take);
    h1 = 1'b0; h2 = 1'b0; f1 = '0; f2 = '0;
    foreach (exp_q[i]) begin
      if (q_a1 != '0 && exp_q[i][AW+DW-1:DW] == q_a1) begin h1 = 1'b1; f1 = exp_q[i][DW-1:0]; end
      if (q_a2 != '0 && exp_q[i][AW+DW-1:DW] == q_a2) begin h2 = 1'b1; f2 = exp_q[i][DW-1:0]; end
    end
    checks++; if (alu_ready !== er_a) begin errors++; $display("FAIL alu_ready got %b exp %b t=%0t", alu_ready, er_a, $time); end
    checks++; if (md_ready !== er_m) begin errors++; $display("FAIL md_ready got %b exp %b t=%0t", md_ready, er_m, $time); end
    checks++; if (count !== CW'(sz)) begin errors++; $display("FAIL count got %0d exp %0d t=%0t", count, sz, $time); end
    checks++; if (empty !== (sz == 0) || full !== (sz == DEPTH)) begin errors++; $display("FAIL flags empty=%b full=%b exp size %0d t=%0t", empty, full, sz, $time); end
    checks++; if (we3 !== (sz > 0)) begin errors++; $display("FAIL we3 got %b exp %b t=%0t", we3, (sz > 0), $time); end
    checks++; if (hit1 !== h1 || fwd1 !== f1) begin errors++; $display("FAIL lookup1 got %b/%h exp %b/%h t=%0t", hit1, fwd1, h1, f1, $time); end
    checks++; if (hit2 !== h2 || fwd2 !== f2) begin errors++; $display("FAIL lookup2 got %b/%h exp %b/%h t=%0t", hit2, fwd2, h2, f2, $time); end
    if (sz > 0) begin
      checks++;
      if ({a3, wd3} !== exp_q[0]) begin errors++; $display("FAIL drain got a3=%0d wd3=%h exp a3=%0d wd3=%h t=%0t", a3, wd3, exp_q[0][AW+DW-1:DW], exp_q[0][DW-1:0], $time); end
      void'(exp_q.pop_front());
    end else begin
      checks++; if (a3 !== '0 || wd3 !== '0) begin errors++; $display("FAIL idle_port got a3=%0d wd3=%h exp 0 t=%0t", a3, wd3, $time); end
    end
    if (a_take) exp_q.push_back({aa, ad});
    if (mv && er_m && ma != '0) exp_q.push_back({ma, md});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_reset;
    cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    @(negedge clk);
    alu_valid = 1'b0; md_valid = 1'b0; q_a1 = 5'd3;
    #2 reset = 1'b0;
    #1;
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got %b exp 0", we3); end
    checks++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_state count=%0d empty=%b full=%b exp 0/1/0", count, empty, full); end
    checks++; if (hit1 !== 1'b0 || fwd1 !== '0 || a3 !== '0 || wd3 !== '0) begin errors++; $display("FAIL reset_outputs hit1=%b fwd1=%h a3=%0d wd3=%h exp zeros", hit1, fwd1, a3, wd3); end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    q_a1 = '0;
    idle(1);
  endtask

  task automatic test_single_write;
    cycle(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0);
    cycle(1'b0, '0, '0, 1'b0, '0, '0);
    idle(1);
  endtask

  task automatic test_dual_accept;
    cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB);
    idle(3);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++)
      cycle(1'b1, AW'(8 + i), 32'h100 + i, 1'b1, AW'(16 + i), 32'h200 + i);
    checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL backpressure_full count=%0d exp %0d", count, DEPTH); end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle(1);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain_bound left=%0d exp 0", exp_q.size()); end
    idle(1);
  endtask

  task automatic test_r0_discard;
    cycle(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0);
    idle(1);
    cycle(1'b1, 5'd9, 32'h9, 1'b1, 5'd0, 32'hFFFF);
    idle(2);
  endtask

  task automatic test_forwarding;
    q_a1 = 5'd7; q_a2 = 5'd9;
    cycle(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
    @(negedge clk); alu_valid = 1'b0; md_valid = 1'b0; #1;
    checks++; if (hit1 !== 1'b1 || fwd1 !== 32'd2) begin errors++; $display("FAIL fwd_youngest got %b/%h exp 1/2", hit1, fwd1); end
    q_a1 = 5'd0; #1;
    checks++; if (hit1 !== 1'b0 || fwd1 !== '0) begin errors++; $display("FAIL fwd_r0 got %b/%h exp 0/0", hit1, fwd1); end
    q_a1 = 5'd7;
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    checks++; if (hit1 !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL fwd_after_drain hit1=%b empty=%b exp 0/1", hit1, empty); end
    q_a1 = '0; q_a2 = '0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      q_a1 = AW'($urandom_range(0, 7));
      q_a2 = AW'($urandom_range(0, 7));
      cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
    end
    idle(DEPTH + 2);
  endtask

  initial begin
    reset = 1'b0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    md_valid = 1'b0; md_addr = '0; md_data = '0;
    q_a1 = '0; q_a2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(1);
    test_reset;
    test_single_write;
    test_dual_accept;
    test_back_to_back;
    test_r0_discard;
    test_forwarding;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
